// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter and its bus mux stage.
package arb_pkg;

  localparam int NUM_MASTERS = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DATA    = 2'd1,
    DONE    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } owner_sel_t;

  // valid is set only for an exactly one-hot vector.
  function automatic owner_sel_t onehot_to_idx(input logic [NUM_MASTERS-1:0] vec);
    owner_sel_t res;
    res.valid = 1'b0;
    res.idx   = 2'd0;
    case (vec)
      4'b0001: begin res.valid = 1'b1; res.idx = 2'd0; end
      4'b0010: begin res.valid = 1'b1; res.idx = 2'd1; end
      4'b0100: begin res.valid = 1'b1; res.idx = 2'd2; end
      4'b1000: begin res.valid = 1'b1; res.idx = 2'd3; end
      default: ;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/arb_owner_mux.sv
// Combinational 4:1 selection of one master's write-channel fields.
module arb_owner_mux
  import arb_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
) (
  input  logic [1:0]                    i_sel,
  input  logic [NUM_MASTERS-1:0]        i_valid,
  input  logic [NUM_MASTERS*ADDR_W-1:0] i_addr,
  input  logic [NUM_MASTERS*LEN_W-1:0]  i_len,
  input  logic [NUM_MASTERS*DATA_W-1:0] i_wdata,
  output logic                          o_valid,
  output logic [ADDR_W-1:0]             o_addr,
  output logic [LEN_W-1:0]              o_len,
  output logic [DATA_W-1:0]             o_wdata
);

  always_comb begin
    o_valid = i_valid[i_sel];
    o_addr  = i_addr[int'(i_sel)*ADDR_W +: ADDR_W];
    o_len   = i_len[int'(i_sel)*LEN_W +: LEN_W];
    o_wdata = i_wdata[int'(i_sel)*DATA_W +: DATA_W];
  end

endmodule

// File: rtl/arb_bus_mux.sv
// Routes the granted master's burst write onto the shared slave port.
// Optional stall watchdog and timeout port: define ARB_BUS_MUX_TIMEOUT_EN.
module arb_bus_mux
  import arb_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_MASTERS-1:0]        gnt,
  input  logic [NUM_MASTERS-1:0]        m_valid,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*LEN_W-1:0]  m_len,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]        m_ready,
  output logic [NUM_MASTERS-1:0]        m_done,
  output logic                          s_valid,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_wdata,
  output logic                          s_last,
  input  logic                          s_ready,
  output logic                          err
`ifdef ARB_BUS_MUX_TIMEOUT_EN
  ,
  output logic                          timeout
`endif
);

  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(DATA_W / 8);

  state_t               r_state;
  state_t               w_nextState;
  logic [1:0]           r_owner;
  logic [ADDR_W-1:0]    r_addr;
  logic [LEN_W-1:0]     r_len;
  logic [LEN_W:0]       r_beatCnt;
  logic                 r_err;

  owner_sel_t           w_gntSel;
  logic                 w_multiGnt;
  logic [1:0]           w_muxSel;
  logic                 w_selValid;
  logic [ADDR_W-1:0]    w_selAddr;
  logic [LEN_W-1:0]     w_selLen;
  logic [DATA_W-1:0]    w_selData;
  logic                 w_inData;
  logic                 w_ownerGnt;
  logic                 w_lastBeat;
  logic                 w_handshake;
  logic                 w_abort;

  assign w_gntSel    = onehot_to_idx(gnt);
  assign w_multiGnt  = |(gnt & (gnt - 4'd1));
  // Before ownership is latched the mux follows the grant, so IDLE can capture addr/len.
  assign w_muxSel    = (r_state == IDLE) ? w_gntSel.idx : r_owner;
  assign w_inData    = (r_state == DATA);
  assign w_ownerGnt  = gnt[r_owner];
  assign w_lastBeat  = ({1'b0, r_len} == r_beatCnt);
  assign w_handshake = s_valid & s_ready;

  arb_owner_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W)
  ) u_ownerMux (
    .i_sel   (w_muxSel),
    .i_valid (m_valid),
    .i_addr  (m_addr),
    .i_len   (m_len),
    .i_wdata (m_wdata),
    .o_valid (w_selValid),
    .o_addr  (w_selAddr),
    .o_len   (w_selLen),
    .o_wdata (w_selData)
  );

`ifdef ARB_BUS_MUX_TIMEOUT_EN
  logic [7:0] r_wdog;
  logic       r_timeout;
  logic       w_stall;
  logic       w_wdogExpire;

  assign w_stall      = (s_valid & ~s_ready) | ~w_selValid;
  // The stall that would take the count to 255 aborts in the same cycle.
  assign w_wdogExpire = w_inData & ~w_handshake & w_stall & (r_wdog == 8'd254);
  assign w_abort      = w_inData & (~w_ownerGnt | w_wdogExpire);
  assign timeout      = r_timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wdog    <= 8'd0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_wdogExpire;
      if (!w_inData || w_handshake) begin
        r_wdog <= 8'd0;
      end else if (w_stall) begin
        r_wdog <= r_wdog + 8'd1;
      end
    end
  end
`else
  assign w_abort = w_inData & ~w_ownerGnt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    s_valid     = w_inData & w_selValid;
    s_last      = w_inData & w_lastBeat;
    s_addr      = r_addr;
    s_wdata     = w_selData;
    m_ready     = '0;
    m_done      = '0;
    err         = r_err;
    case (r_state)
      IDLE: begin
        if (w_gntSel.valid) w_nextState = DATA;
      end
      DATA: begin
        m_ready[r_owner] = s_ready;
        if (w_abort) begin
          w_nextState = IDLE;
        end else if (w_handshake && w_lastBeat) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        m_done[r_owner] = 1'b1;
        w_nextState     = RELEASE;
      end
      RELEASE: begin
        // A grant to the next master is only looked at once back in IDLE.
        if (!w_ownerGnt) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner   <= 2'd0;
      r_addr    <= '0;
      r_len     <= '0;
      r_beatCnt <= '0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gntSel.valid) begin
            r_owner   <= w_gntSel.idx;
            r_addr    <= w_selAddr;
            r_len     <= w_selLen;
            r_beatCnt <= '0;
          end else if (w_multiGnt) begin
            r_err <= 1'b1;
          end
        end
        DATA: begin
          if (w_abort) begin
            r_err <= 1'b1;
          end else if (w_handshake) begin
            r_addr    <= r_addr + ADDR_STEP;
            r_beatCnt <= r_beatCnt + (LEN_W+1)'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_arb_bus_mux.sv
// Self-checking bench for arb_bus_mux: beat scoreboard plus directed checks.
// Define ARB_BUS_MUX_TIMEOUT_EN to also exercise the stall watchdog.
module tb_arb_bus_mux;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 4;

  logic                clk;
  logic                rst;
  logic [3:0]          gnt;
  logic [3:0]          m_valid;
  logic [4*ADDR_W-1:0] m_addr;
  logic [4*LEN_W-1:0]  m_len;
  logic [4*DATA_W-1:0] m_wdata;
  logic [3:0]          m_ready;
  logic [3:0]          m_done;
  logic                s_valid;
  logic [ADDR_W-1:0]   s_addr;
  logic [DATA_W-1:0]   s_wdata;
  logic                s_last;
  logic                s_ready;
  logic                err;
`ifdef ARB_BUS_MUX_TIMEOUT_EN
  logic                timeout;
`endif

  arb_bus_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .gnt     (gnt),
    .m_valid (m_valid),
    .m_addr  (m_addr),
    .m_len   (m_len),
    .m_wdata (m_wdata),
    .m_ready (m_ready),
    .m_done  (m_done),
    .s_valid (s_valid),
    .s_addr  (s_addr),
    .s_wdata (s_wdata),
    .s_last  (s_last),
    .s_ready (s_ready),
    .err     (err)
`ifdef ARB_BUS_MUX_TIMEOUT_EN
    ,
    .timeout (timeout)
`endif
  );

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    logic        last;
    logic [3:0]  mask;
  } beat_t;

  beat_t      expQ[$];
  logic [3:0] pendDone = 4'd0;
  int         checks = 0;
  int         errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global time limit exceeded");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] dataFor(input int idx);
    return 32'hA5A5_0000 + 32'(idx) * 32'h0101_0011;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Program master idx and queue the beats the slave should see from it.
  task automatic applyStimulus(input int idx, input logic [15:0] addr, input logic [3:0] len,
                               input int nBeats, input bit grantNow);
    beat_t b;
    m_addr[idx*ADDR_W +: ADDR_W]  = addr;
    m_len[idx*LEN_W +: LEN_W]     = len;
    m_wdata[idx*DATA_W +: DATA_W] = dataFor(idx);
    m_valid[idx]                  = 1'b1;
    if (grantNow) gnt = 4'b0001 << idx;
    for (int k = 0; k < nBeats; k++) begin
      b.addr = 16'((int'(addr) + k * (DATA_W / 8)) % 65536);
      b.data = dataFor(idx);
      b.last = (k == int'(len));
      b.mask = 4'b0001 << idx;
      expQ.push_back(b);
    end
  endtask

  task automatic waitDone(input int idx, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (m_done[idx]) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput($sformatf("done_m%0d_seen", idx), 32'(seen), 32'd1);
  endtask

  task automatic releaseGrant();
    tick();
    gnt     = 4'd0;
    m_valid = 4'd0;
    tick();
    tick();
    checkOutput("beats_left", 32'(expQ.size()), 32'd0);
  endtask

  task automatic doReset();
    rst     = 1'b1;
    gnt     = 4'd0;
    m_valid = 4'd0;
    s_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Scoreboard: every handshake must match the next queued beat; m_done pulses
  // exactly one cycle after a last beat and never otherwise.
  always @(negedge clk) begin
    logic [3:0] expDone;
    beat_t      b;
    if (!rst) begin
      expDone  = pendDone;
      pendDone = 4'd0;
      if (s_valid && s_ready) begin
        checkOutput("beat_expected", 32'(expQ.size() != 0), 32'd1);
        if (expQ.size() != 0) begin
          b = expQ.pop_front();
          checkOutput("beat_addr", 32'(s_addr), 32'(b.addr));
          checkOutput("beat_data", s_wdata, b.data);
          checkOutput("beat_last", 32'(s_last), 32'(b.last));
          checkOutput("beat_m_ready", 32'(m_ready), 32'(b.mask));
          if (b.last) pendDone = b.mask;
        end
      end
      checkOutput("m_done", 32'(m_done), 32'(expDone));
    end
  end

  initial begin
    int stalls;
    bit seen;
    rst     = 1'b1;
    gnt     = 4'd0;
    m_valid = 4'd0;
    m_addr  = '0;
    m_len   = '0;
    m_wdata = '0;
    s_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    @(negedge clk);
    checkOutput("rst_s_valid", 32'(s_valid), 32'd0);
    checkOutput("rst_m_ready", 32'(m_ready), 32'd0);
    checkOutput("rst_m_done", 32'(m_done), 32'd0);
    checkOutput("rst_s_addr", 32'(s_addr), 32'd0);
    checkOutput("rst_s_last", 32'(s_last), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);

    $display("[TB] single burst, master 2");
    tick();
    applyStimulus(2, 16'h0100, 4'd3, 4, 1'b1);
    s_ready = 1'b1;
    @(negedge clk);
    checkOutput("t1_idle_s_valid", 32'(s_valid), 32'd0);
    tick();
    @(negedge clk);
    checkOutput("t1_first_s_valid", 32'(s_valid), 32'd1);
    checkOutput("t1_first_s_addr", 32'(s_addr), 32'h0100);
    waitDone(2, 10);
    checkOutput("t1_final_addr", 32'(s_addr), 32'h0110);
    releaseGrant();

    $display("[TB] backpressure, master 0");
    applyStimulus(0, 16'h0200, 4'd1, 2, 1'b1);
    s_ready = 1'b1;
    @(negedge clk);
    checkOutput("t2_idle_m_ready", 32'(m_ready), 32'd0);
    tick();
    s_ready = 1'b0;
    @(negedge clk);
    checkOutput("t2_stall_m_ready", 32'(m_ready), 32'd0);
    checkOutput("t2_stall_s_valid", 32'(s_valid), 32'd1);
    tick();
    s_ready = 1'b1;
    @(negedge clk);
    checkOutput("t2_hs_m_ready", 32'(m_ready), 32'b0001);
    tick();
    s_ready = 1'b0;
    @(negedge clk);
    checkOutput("t2_held_s_addr", 32'(s_addr), 32'h0204);
    checkOutput("t2_held_s_last", 32'(s_last), 32'd1);
    tick();
    s_ready = 1'b1;
    waitDone(0, 5);
    releaseGrant();

    $display("[TB] zero-length burst with address wrap, master 1");
    applyStimulus(1, 16'hFFFC, 4'd0, 1, 1'b1);
    s_ready = 1'b1;
    tick();
    @(negedge clk);
    checkOutput("t3_s_last", 32'(s_last), 32'd1);
    waitDone(1, 5);
    checkOutput("t3_wrap_addr", 32'(s_addr), 32'h0000);
    releaseGrant();

    $display("[TB] multi-hot grant");
    gnt     = 4'b0011;
    m_valid = 4'b0011;
    s_ready = 1'b1;
    @(negedge clk);
    checkOutput("t4_multi_s_valid", 32'(s_valid), 32'd0);
    tick();
    gnt = 4'd0;
    @(negedge clk);
    checkOutput("t4_multi_err", 32'(err), 32'd1);
    checkOutput("t4_multi_s_valid2", 32'(s_valid), 32'd0);
    tick();
    tick();
    @(negedge clk);
    checkOutput("t4_err_sticky", 32'(err), 32'd1);
    tick();
    doReset();
    @(negedge clk);
    checkOutput("t4_err_cleared", 32'(err), 32'd0);

    $display("[TB] grant loss mid-burst, master 1");
    applyStimulus(1, 16'h0300, 4'd3, 1, 1'b1);
    s_ready = 1'b1;
    tick();
    tick();
    gnt     = 4'd0;
    s_ready = 1'b0;
    @(negedge clk);
    checkOutput("t4b_err_before_abort", 32'(err), 32'd0);
    tick();
    @(negedge clk);
    checkOutput("t4b_s_valid", 32'(s_valid), 32'd0);
    checkOutput("t4b_err", 32'(err), 32'd1);
    m_valid = 4'd0;
    tick();
    tick();
    tick();
    checkOutput("t4b_beats_left", 32'(expQ.size()), 32'd0);
    doReset();

    $display("[TB] back-to-back owners 3 then 0");
    applyStimulus(3, 16'h0400, 4'd1, 2, 1'b1);
    applyStimulus(0, 16'h0500, 4'd0, 1, 1'b0);
    s_ready = 1'b1;
    waitDone(3, 10);
    tick();
    gnt = 4'b0001;
    @(negedge clk);
    checkOutput("t5_release_s_valid", 32'(s_valid), 32'd0);
    tick();
    @(negedge clk);
    checkOutput("t5_idle_s_valid", 32'(s_valid), 32'd0);
    tick();
    @(negedge clk);
    checkOutput("t5_m0_s_valid", 32'(s_valid), 32'd1);
    checkOutput("t5_m0_s_addr", 32'(s_addr), 32'h0500);
    waitDone(0, 5);
    releaseGrant();

    $display("[TB] reset mid-burst, master 2");
    applyStimulus(2, 16'h0600, 4'd7, 2, 1'b1);
    s_ready = 1'b1;
    tick();
    tick();
    tick();
    rst     = 1'b1;
    s_ready = 1'b0;
    tick();
    s_ready = 1'b1;
    @(negedge clk);
    checkOutput("t6_rst_s_valid", 32'(s_valid), 32'd0);
    checkOutput("t6_rst_m_ready", 32'(m_ready), 32'd0);
    checkOutput("t6_rst_m_done", 32'(m_done), 32'd0);
    checkOutput("t6_rst_s_addr", 32'(s_addr), 32'd0);
    checkOutput("t6_rst_s_last", 32'(s_last), 32'd0);
    checkOutput("t6_rst_err", 32'(err), 32'd0);
    checkOutput("t6_beats_left", 32'(expQ.size()), 32'd0);
    tick();
    gnt     = 4'd0;
    m_valid = 4'd0;
    s_ready = 1'b0;
    rst     = 1'b0;
    tick();

`ifdef ARB_BUS_MUX_TIMEOUT_EN
    $display("[TB] stall watchdog, master 0");
    applyStimulus(0, 16'h0700, 4'd0, 0, 1'b1);
    s_ready = 1'b0;
    tick();
    stalls = 0;
    seen   = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (timeout) begin
        seen = 1'b1;
        break;
      end
      if (s_valid) stalls++;
    end
    gnt     = 4'd0;
    m_valid = 4'd0;
    checkOutput("t7_timeout_seen", 32'(seen), 32'd1);
    checkOutput("t7_stall_cycles", 32'(stalls), 32'd255);
    checkOutput("t7_err", 32'(err), 32'd1);
    checkOutput("t7_s_valid", 32'(s_valid), 32'd0);
    tick();
    @(negedge clk);
    checkOutput("t7_timeout_pulse", 32'(timeout), 32'd0);
    doReset();
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
